// File: rtl/seq_pkg.sv
// Constants shared between the test-sequence generator and this checker:
// the 8-byte pattern, its start marker and the checker state encoding.
package seq_pkg;

    localparam int SEQ_LEN = 8;

    localparam logic [7:0] SEQ_START = 8'hAF;

    localparam logic [7:0] SEQ_ROM [0:SEQ_LEN-1] = '{
        8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
    };

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_e;

    function automatic logic [7:0] seq_byte(input logic [2:0] pos);
        return SEQ_ROM[pos];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for the repeating 8-byte test sequence: hunts for the
// start byte, tracks position, flags completions/mismatches and declares lock.
module sequence_checker
    import seq_pkg::*;
#(
    parameter int LOCK_THRESHOLD = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    input  logic                 clear_counts,
    output logic                 seq_done,
    output logic                 mismatch,
    output logic                 locked,
    output logic [7:0]           expected_byte,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [CNT_WIDTH-1:0] error_count
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_THRESHOLD);

    state_e     state_q, state_d;
    logic [2:0] pos_q, pos_d;
    logic [3:0] good_run_q, good_run_d;
    logic       locked_q, locked_d;
    logic       seq_done_q, seq_done_d;
    logic       mismatch_q, mismatch_d;
    logic       inc_match, inc_error;

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        good_run_d = good_run_q;
        locked_d   = locked_q;
        seq_done_d = 1'b0;
        mismatch_d = 1'b0;
        inc_match  = 1'b0;
        inc_error  = 1'b0;

        if (data_valid) begin
            if (state_q == HUNT) begin
                if (data_in == SEQ_START) begin
                    state_d = TRACK;
                    pos_d   = 3'd1;
                end
            end else if (data_in == seq_byte(pos_q)) begin
                if (pos_q == 3'd7) begin
                    pos_d      = 3'd0;
                    seq_done_d = 1'b1;
                    inc_match  = 1'b1;
                    if (good_run_q < LOCK_RUN) begin
                        good_run_d = good_run_q + 4'd1;
                    end
                    locked_d = (good_run_d == LOCK_RUN);
                end else begin
                    pos_d = pos_q + 3'd1;
                end
            end else begin
                mismatch_d = 1'b1;
                inc_error  = 1'b1;
                good_run_d = 4'd0;
                locked_d   = 1'b0;
                // 0xAF appears only at index 0, so it is always a valid restart point.
                if (data_in == SEQ_START) begin
                    state_d = TRACK;
                    pos_d   = 3'd1;
                end else begin
                    state_d = HUNT;
                    pos_d   = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            pos_q      <= 3'd0;
            good_run_q <= 4'd0;
            locked_q   <= 1'b0;
            seq_done_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            good_run_q <= good_run_d;
            locked_q   <= locked_d;
            seq_done_q <= seq_done_d;
            mismatch_q <= mismatch_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_counts),
        .inc   (inc_match),
        .count (match_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_error_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_counts),
        .inc   (inc_error),
        .count (error_count)
    );

    assign seq_done      = seq_done_q;
    assign mismatch      = mismatch_q;
    assign locked        = locked_q;
    assign expected_byte = seq_byte(pos_q);

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: a default instance plus a CNT_WIDTH=2
// instance sharing the same stimulus for saturation checks.
module tb_sequence_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        clear_counts = 1'b0;

    logic        seq_done, mismatch, locked;
    logic [7:0]  expected_byte;
    logic [15:0] match_count, error_count;

    logic        seq_done2, mismatch2, locked2;
    logic [7:0]  expected_byte2;
    logic [1:0]  match_count2, error_count2;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] SEQ [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

    always #5 clk = ~clk;

    sequence_checker #(.LOCK_THRESHOLD(2), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .clear_counts  (clear_counts),
        .seq_done      (seq_done),
        .mismatch      (mismatch),
        .locked        (locked),
        .expected_byte (expected_byte),
        .match_count   (match_count),
        .error_count   (error_count)
    );

    sequence_checker #(.LOCK_THRESHOLD(2), .CNT_WIDTH(2)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .clear_counts  (clear_counts),
        .seq_done      (seq_done2),
        .mismatch      (mismatch2),
        .locked        (locked2),
        .expected_byte (expected_byte2),
        .match_count   (match_count2),
        .error_count   (error_count2)
    );

    // Drive one valid byte at the falling edge; return 1 ns after the capturing edge.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(negedge clk);
        data_in      = b;
        data_valid   = 1'b1;
        clear_counts = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        data_valid   = 1'b0;
        data_in      = 8'h00;
        clear_counts = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_seq(output int done_pulses, output int mm_pulses);
        done_pulses = 0;
        mm_pulses   = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(SEQ[i], 1'b0);
            if (seq_done) done_pulses++;
            if (mismatch) mm_pulses++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        total_cnt++;
        if ({seq_done, mismatch, locked, match_count, error_count} !== 19'd0) begin
            $display("FAIL reset_outputs: got %b, want all zero", {seq_done, mismatch, locked, match_count, error_count});
        end else pass_cnt++;
        total_cnt++;
        if (expected_byte !== 8'hAF) $display("FAIL reset_expected: got %h, want af", expected_byte);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_seq();
        int mm;
        mm = 0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            send_byte(SEQ[i], 1'b0);
            if (mismatch) mm++;
        end
        total_cnt++;
        if (seq_done !== 1'b0) $display("FAIL single_early_done: got %b, want 0", seq_done);
        else pass_cnt++;
        total_cnt++;
        if (expected_byte !== 8'h8D) $display("FAIL single_expected7: got %h, want 8d", expected_byte);
        else pass_cnt++;
        send_byte(8'h8D, 1'b0);
        if (mismatch) mm++;
        total_cnt++;
        if (seq_done !== 1'b1) $display("FAIL single_done: got %b, want 1", seq_done);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 16'd1) $display("FAIL single_match_count: got %0d, want 1", match_count);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL single_locked: got %b, want 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (mm !== 0) $display("FAIL single_mismatch: got %0d pulses, want 0", mm);
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (seq_done !== 1'b0) $display("FAIL single_done_pulse: got %b, want 0", seq_done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d, m;
        apply_reset();
        send_seq(d, m);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL b2b_locked_first: got %b, want 0", locked);
        else pass_cnt++;
        send_seq(d, m);
        total_cnt++;
        if ({seq_done, locked} !== 2'b11) $display("FAIL b2b_locked_second: got done/locked %b, want 11", {seq_done, locked});
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 16'd2) $display("FAIL b2b_match_count: got %0d, want 2", match_count);
        else pass_cnt++;
        send_byte(8'hAF, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'hE2, 1'b0);
        total_cnt++;
        if (mismatch !== 1'b0) $display("FAIL b2b_early_mismatch: got %b, want 0", mismatch);
        else pass_cnt++;
        send_byte(8'h00, 1'b0);
        total_cnt++;
        if ({mismatch, locked} !== 2'b10) $display("FAIL b2b_mismatch: got mismatch/locked %b, want 10", {mismatch, locked});
        else pass_cnt++;
        total_cnt++;
        if (error_count !== 16'd1) $display("FAIL b2b_error_count: got %0d, want 1", error_count);
        else pass_cnt++;
        total_cnt++;
        if (expected_byte !== 8'hAF) $display("FAIL b2b_hunt_expected: got %h, want af", expected_byte);
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (mismatch !== 1'b0) $display("FAIL b2b_mismatch_pulse: got %b, want 0", mismatch);
        else pass_cnt++;
    endtask

    task automatic test_resync();
        int d, m;
        apply_reset();
        for (int i = 0; i < 4; i++) send_byte(SEQ[i], 1'b0);
        send_byte(8'hAF, 1'b0);
        total_cnt++;
        if (mismatch !== 1'b1) $display("FAIL resync_mismatch: got %b, want 1", mismatch);
        else pass_cnt++;
        total_cnt++;
        if (expected_byte !== 8'hBC) $display("FAIL resync_expected: got %h, want bc (no HUNT)", expected_byte);
        else pass_cnt++;
        d = 0; m = 0;
        for (int i = 1; i < 8; i++) begin
            send_byte(SEQ[i], 1'b0);
            if (seq_done) d++;
            if (mismatch) m++;
        end
        total_cnt++;
        if ({seq_done, 31'(d), 32'(m)} !== {1'b1, 31'd1, 32'd0}) begin
            $display("FAIL resync_done: got done=%b pulses=%0d mm=%0d, want 1/1/0", seq_done, d, m);
        end else pass_cnt++;
        total_cnt++;
        if ({match_count, error_count} !== {16'd1, 16'd1}) begin
            $display("FAIL resync_counts: got match=%0d err=%0d, want 1/1", match_count, error_count);
        end else pass_cnt++;
    endtask

    task automatic test_hunt_and_gaps();
        logic [7:0] idle_bytes [4];
        int m, d;
        idle_bytes = '{8'h00, 8'hE2, 8'hFF, 8'h8D};
        apply_reset();
        m = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(idle_bytes[i], 1'b0);
            if (mismatch) m++;
        end
        total_cnt++;
        if (m !== 0) $display("FAIL hunt_mismatch: got %0d pulses, want 0", m);
        else pass_cnt++;
        total_cnt++;
        if ({error_count, expected_byte} !== {16'd0, 8'hAF}) begin
            $display("FAIL hunt_state: got err=%0d exp=%h, want 0/af", error_count, expected_byte);
        end else pass_cnt++;
        d = 0; m = 0;
        for (int i = 0; i < 8; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                idle_cycle();
                if (seq_done) d++;
                if (mismatch) m++;
            end
            send_byte(SEQ[i], 1'b0);
            if (seq_done) d++;
            if (mismatch) m++;
        end
        idle_cycle();
        if (seq_done) d++;
        total_cnt++;
        if ({32'(d), 32'(m)} !== {32'd1, 32'd0}) $display("FAIL gaps_done: got done=%0d mm=%0d, want 1/0", d, m);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 16'd1) $display("FAIL gaps_match_count: got %0d, want 1", match_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d, m;
        apply_reset();
        send_seq(d, m);
        for (int i = 0; i < 4; i++) send_byte(SEQ[i], 1'b0);
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({match_count, expected_byte, seq_done, mismatch, locked} !== {16'd0, 8'hAF, 3'b000}) begin
            $display("FAIL midreset_outputs: got match=%0d exp=%h", match_count, expected_byte);
        end else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        send_seq(d, m);
        total_cnt++;
        if ({seq_done, match_count} !== {1'b1, 16'd1}) begin
            $display("FAIL midreset_after: got done=%b match=%0d, want 1/1", seq_done, match_count);
        end else pass_cnt++;
    endtask

    task automatic test_saturate_clear();
        int d, m;
        apply_reset();
        for (int s = 0; s < 5; s++) send_seq(d, m);
        total_cnt++;
        if (match_count2 !== 2'd3) $display("FAIL sat_match_count: got %0d, want 3", match_count2);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 16'd5) $display("FAIL sat_wide_count: got %0d, want 5", match_count);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) send_byte(SEQ[i], 1'b0);
        send_byte(8'h8D, 1'b1);
        total_cnt++;
        if ({seq_done2, match_count2, match_count} !== {1'b1, 2'd0, 16'd0}) begin
            $display("FAIL clear_with_done: got done=%b m2=%0d m=%0d, want 1/0/0", seq_done2, match_count2, match_count);
        end else pass_cnt++;
        total_cnt++;
        if (locked2 !== 1'b1) $display("FAIL clear_keeps_lock: got %b, want 1", locked2);
        else pass_cnt++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_seq();
        test_back_to_back();
        test_resync();
        test_hunt_and_gaps();
        test_reset_mid();
        test_saturate_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
